// File: rtl/dc_line_window_buffer.sv
// rtl/dc_line_window_buffer.sv - ring of TAPS+1 line memories emitting TAPS-high vertical pixel windows
// Write side fills lines in raster order; read side streams clamped windows with line repeat.
module dc_line_window_buffer #(
  parameter int BITS_PER_PIXEL        = 24,
  parameter int TAPS                  = 4,
  parameter int MAX_PIXELS            = 128,
  parameter int ADDR_WIDTH            = 7,
  parameter int PIXELS_PER_LINE_WIDTH = 8,
  parameter int LINES_WIDTH           = 11
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             frame_start,
  input  logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
  input  logic [LINES_WIDTH-1:0]           lines_per_frame,
  input  logic [BITS_PER_PIXEL-1:0]        in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             out_repeat,
  output logic [TAPS*BITS_PER_PIXEL-1:0]   out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_eol,
  output logic                             out_eof
);

  localparam int NBUF = TAPS + 1;
  localparam int BW   = $clog2(NBUF);
  localparam int LW   = LINES_WIDTH;
  localparam int PW   = PIXELS_PER_LINE_WIDTH;

  logic [BITS_PER_PIXEL-1:0] mem [NBUF][MAX_PIXELS];

  logic [ADDR_WIDTH-1:0]          wr_x, rd_x;
  logic [LW-1:0]                  wr_line, rel_line, b;
  logic [BW-1:0]                  wr_buf, base_buf;
  logic                           out_valid_r, out_eol_r, out_eof_r;
  logic [TAPS*BITS_PER_PIXEL-1:0] out_data_r;

  logic [PW-1:0] w_last;
  logic [LW-1:0] h_last, occupancy, b_eff, wr_line_eff;
  logic [BW-1:0] base_eff;
  logic [LW:0]   need_line, lim_line;
  logic          wr_at_end, rd_at_end, wr_fire, acc, eol_acc;
  logic          b_at_last, frame_done, b_step, rel_inc, win_ready, issue;
  logic [BW-1:0] tap_sel [TAPS];

  function automatic logic [BW-1:0] buf_inc(input logic [BW-1:0] p);
    return (p == BW'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  // Buffer of the clamped source line for tap k, derived from the base pointer
  // by a bounded offset (-1 .. TAPS-2) so one conditional wrap suffices.
  function automatic logic [BW-1:0] tap_buf(input int k, input int bb, input int base, input int h);
    int ln;
    int s;
    ln = bb + k - 1;
    if (ln < 0) ln = 0;
    if (ln > h - 1) ln = h - 1;
    s = base + ln - bb;
    if (s < 0) s = s + NBUF;
    else if (s >= NBUF) s = s - NBUF;
    return BW'(s);
  endfunction

  assign w_last    = pixels_per_line - 1'b1;
  assign h_last    = lines_per_frame - 1'b1;
  assign wr_at_end = (PW'(wr_x) == w_last);
  assign rd_at_end = (PW'(rd_x) == w_last);
  assign occupancy = wr_line - rel_line;

  assign in_ready  = en && (wr_line < lines_per_frame) && (occupancy < LW'(NBUF));
  assign wr_fire   = in_valid && in_ready && !frame_start;

  assign acc        = en && out_valid_r && out_ready;
  assign eol_acc    = acc && out_eol_r;
  assign b_at_last  = (b == h_last);
  assign frame_done = eol_acc && !out_repeat && b_at_last;
  assign b_step     = eol_acc && !out_repeat && !b_at_last;
  assign rel_inc    = b_step && (b != '0);

  // The window decision made at eol acceptance is visible to this cycle's
  // read so the next window can start without a bubble.
  assign b_eff       = frame_done ? '0 : (b_step ? b + 1'b1 : b);
  assign base_eff    = frame_done ? '0 : (b_step ? buf_inc(base_buf) : base_buf);
  assign wr_line_eff = frame_done ? '0 : wr_line;

  assign need_line = {1'b0, b_eff} + (LW+1)'(TAPS - 2);
  assign lim_line  = (need_line > {1'b0, h_last}) ? {1'b0, h_last} : need_line;
  assign win_ready = ({1'b0, wr_line_eff} > lim_line);
  assign issue     = en && !frame_start && win_ready && (!out_valid_r || out_ready);

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      tap_sel[k] = tap_buf(k, int'(b_eff), int'(base_eff), int'(lines_per_frame));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem[wr_buf][wr_x] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_x        <= '0;
      rd_x        <= '0;
      wr_line     <= '0;
      rel_line    <= '0;
      b           <= '0;
      wr_buf      <= '0;
      base_buf    <= '0;
      out_valid_r <= 1'b0;
      out_eol_r   <= 1'b0;
      out_eof_r   <= 1'b0;
      out_data_r  <= '0;
    end else if (en) begin
      if (frame_start) begin
        wr_x        <= '0;
        rd_x        <= '0;
        wr_line     <= '0;
        rel_line    <= '0;
        b           <= '0;
        wr_buf      <= '0;
        base_buf    <= '0;
        out_valid_r <= 1'b0;
        out_eol_r   <= 1'b0;
        out_eof_r   <= 1'b0;
      end else begin
        if (wr_fire) begin
          if (wr_at_end) begin
            wr_x    <= '0;
            wr_line <= wr_line + 1'b1;
            wr_buf  <= buf_inc(wr_buf);
          end else begin
            wr_x <= wr_x + 1'b1;
          end
        end
        // A completed frame has every line written, so no write competes here.
        if (frame_done) begin
          wr_line  <= '0;
          rel_line <= '0;
          wr_buf   <= '0;
        end else if (rel_inc) begin
          rel_line <= rel_line + 1'b1;
        end
        b        <= b_eff;
        base_buf <= base_eff;
        if (issue) begin
          for (int k = 0; k < TAPS; k++) begin
            out_data_r[k*BITS_PER_PIXEL +: BITS_PER_PIXEL] <= mem[tap_sel[k]][rd_x];
          end
          out_valid_r <= 1'b1;
          out_eol_r   <= rd_at_end;
          out_eof_r   <= rd_at_end && (b_eff == h_last);
          rd_x        <= rd_at_end ? '0 : rd_x + 1'b1;
        end else if (acc) begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_r && en;
  assign out_data  = out_data_r;
  assign out_eol   = out_eol_r;
  assign out_eof   = out_eof_r;

endmodule

// File: doc/dc_line_window_buffer.md
# dc_line_window_buffer

Parametrised successor of the display-controller line buffering unit. Stores incoming scaler-input pixels in a ring of TAPS+1 line memories. Emits one vertical window of TAPS pixels per cycle (source lines b-1 … b+TAPS-2, clamped at frame top and bottom) over a valid/ready handshake. Supports line repeat for vertical upscaling and full back-pressure on both sides. Sits between the input pixel FIFO and the vertical interpolation filter.

## Interface
- BITS_PER_PIXEL, 24: pixel width.
- TAPS, 4: window height, ≥ 2; number of line memories is TAPS+1.
- MAX_PIXELS, 128: memory depth, in pixels per line.
- ADDR_WIDTH, 7: ≥ clog2(MAX_PIXELS).
- PIXELS_PER_LINE_WIDTH, 8: width of pixels_per_line.
- LINES_WIDTH, 11: width of lines_per_frame and the line counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; 0 freezes all state.
- frame_start  in  1  synchronous flush pulse; aborts the current frame.
- pixels_per_line  in  PIXELS_PER_LINE_WIDTH  W, 1..MAX_PIXELS; static within a frame.
- lines_per_frame  in  LINES_WIDTH  H, ≥ 1; static within a frame.
- in_data  in  BITS_PER_PIXEL  input pixel, raster order.
- in_valid  in  1  input handshake.
- in_ready  out  1  input handshake.
- out_repeat  in  1  sampled at acceptance of an out_eol beat; 1 = re-emit the same window.
- out_data  out  TAPS*BITS_PER_PIXEL  tap k at [k*BITS_PER_PIXEL +: BITS_PER_PIXEL]; k=0 is the topmost line.
- out_valid  out  1  output handshake.
- out_ready  in  1  output handshake.
- out_eol  out  1  beat is pixel W-1 of the window line.
- out_eof  out  1  beat is the last pixel of the last window of the frame.

## Operation
- Write side:
  - Counters wr_x (0..W-1) and wr_line (0..H).
  - Write occurs when in_valid && in_ready, into buffer wr_line mod (TAPS+1) at address wr_x.
  - At wr_x = W-1: wr_x clears and wr_line increments.
  - in_ready = en && wr_line < H && (wr_line − rel_line) < TAPS+1.
  - rel_line counts lines released back to the writer.
- Window base b: 0..H-1.
  - Tap k reads source line clamp(b+k−1, 0, H−1), from buffer (line mod (TAPS+1)).
  - Buffer index is kept by wrapping pointers; no divider.
- Window ready when wr_line > min(b+TAPS−2, H−1), i.e. all needed lines are completely written.
- Read side:
  - Counter rd_x (0..W-1).
  - Read issues when en && window ready && (!out_valid || out_ready).
  - An issue reads all TAPS memories at rd_x and increments rd_x.
  - Memory output registers are the out_data registers; they hold while not re-read.
- End of window line (out_eol beat accepted):
  - out_repeat=1: b unchanged; rd_x restarts at 0.
  - out_repeat=0 and b < H−1: b increments. If b ≥ 1 before the increment, line b−1 is released (rel_line++).
  - out_repeat=0 and b = H−1: frame done. wr_line, rel_line, b, rd_x and the ring pointers clear, ready for the next frame's line 0.
- Release and write in the same cycle: both counters update; occupancy stays consistent.
- frame_start=1: all counters, pointers, out_valid, out_eol and out_eof clear next cycle; memory contents are not cleared. This takes priority over any simultaneous handshake.
- en=0: no state changes; in_ready=0; out_valid forced to 0 at the port, and the internal register holds.
- Reads never target the buffer being written: the ready rule guarantees this.

## Timing
- Reset values: out_valid=0, out_eol=0, out_eof=0, out_data=0, all counters and pointers 0. in_ready=1 on the first enabled cycle after reset release.
- Write-to-read latency:
  - First out_valid is 1 cycle after the cycle in which the write of pixel W−1 of source line min(TAPS−2, H−1) completes. That is the first cycle the window is ready plus one read cycle.
  - Example for TAPS=4: after line 2 completes.
- Throughput: 1 beat per cycle with out_ready held 1, including across eol→next window when that window is already ready.
- Output stall: out_data, out_eol and out_eof stay stable while out_valid && !out_ready.
- The input side is fully registered; in_ready is combinational from registered state only.
- W=1: every beat has out_eol=1. H=1: all taps carry line 0; out_eof on its single window (unless repeated).

## Test plan
- TAPS=4, W=8, H=6, pixel value = line*16+x, both sides always ready. Expected: 6 windows × 8 beats. Window 0 taps are lines (0,0,1,2). Window 5 taps are lines (4,5,5,5). out_eof on beat 47 only. First out_valid 1 cycle after pixel (2,7) is written.
- Same stream with out_ready held 0. Expected: in_ready drops after 5 full lines (40 pixels) and stays 0. out_data is frozen on beat 0.
- out_repeat=1 on the eol of windows 1 and 3. Expected: 8 windows; windows 1 and 3 are each emitted twice with identical data; total 64 beats.
- H=1, W=1, TAPS=4. Expected: a single beat with all taps = pixel 0, out_eol=out_eof=1. in_ready=0 until that beat is accepted, then 1.
- frame_start pulsed mid-window 2. Expected: out_valid=0 next cycle; a fresh frame then restarts with window 0 = lines (0,0,1,2) of the new data.
- rst asserted asynchronously mid-line, with in_valid and in_ready high. Expected: outputs go to reset values immediately, and no write is counted.
